// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared types for the multicycle control FSM
// States, opcodes and the aluop / alusrcb / pcsrc encodings.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE,
    ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [1:0] {
    SRCB_REGB    = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } srcb_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control bundle between the FSM and the datapath
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pcen;
  logic       irwrite;
  logic       memwrite;
  logic       regwrite;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsrc;
  logic       illegal;
  logic       timeout;
  logic       halted;

  modport master (
    input  op, zero, mem_ready,
    output pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, aluop, pcsrc, illegal, timeout, halted
  );

  modport slave (
    output op, zero, mem_ready,
    input  pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, aluop, pcsrc, illegal, timeout, halted
  );
endinterface

// File: rtl/multicycle_ctrl_wait_timer.sv
// rtl/multicycle_ctrl_wait_timer.sv - mem_ready wait watchdog (mc_wait_timer)
// expire flags the cycle in which the wait count would reach TIMEOUT; TIMEOUT=0 disables it.
module mc_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  output logic expire
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!active || ready) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (TIMEOUT > 0) && active && !ready && (cnt_q == LIMIT - CW'(1));
endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM of the multicycle MIPS-subset core
// Optional bne support under `MULTICYCLE_CTRL_BNE_EN.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);
  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   timeout_q, timeout_d;

  logic   pcen_c, irwrite_c, memwrite_c, regwrite_c;
  logic   iord_c, memtoreg_c, regdst_c, alusrca_c;
  srcb_t  alusrcb_c;
  aluop_t aluop_c;
  pcsrc_t pcsrc_c;

  logic   wait_active, wait_expire;

  assign wait_active = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);

  mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .active (wait_active),
    .ready  (bus.mem_ready),
    .expire (wait_expire)
  );

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    pcen_c     = 1'b0;
    irwrite_c  = 1'b0;
    memwrite_c = 1'b0;
    regwrite_c = 1'b0;
    iord_c     = 1'b0;
    memtoreg_c = 1'b0;
    regdst_c   = 1'b0;
    alusrca_c  = 1'b0;
    alusrcb_c  = SRCB_REGB;
    aluop_c    = ALUOP_ADD;
    pcsrc_c    = PCSRC_ALU;
    case (state_q)
      FETCH: begin
        alusrcb_c = SRCB_FOUR;
        irwrite_c = bus.mem_ready;
        pcen_c    = bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = DECODE;
        end else if (wait_expire) begin
          state_d   = HALT;
          timeout_d = 1'b1;
        end
      end
      DECODE: begin
        alusrcb_c = SRCB_IMM_SH2;
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
`ifdef MULTICYCLE_CTRL_BNE_EN
          OP_BNE:       state_d = BRANCH;
`endif
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            state_d   = HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = SRCB_IMM;
        state_d   = (bus.op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord_c = 1'b1;
        if (bus.mem_ready) begin
          state_d = MEMWB;
        end else if (wait_expire) begin
          state_d   = HALT;
          timeout_d = 1'b1;
        end
      end
      MEMWB: begin
        memtoreg_c = 1'b1;
        regwrite_c = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        iord_c     = 1'b1;
        memwrite_c = 1'b1;
        if (bus.mem_ready) begin
          state_d = FETCH;
        end else if (wait_expire) begin
          state_d   = HALT;
          timeout_d = 1'b1;
        end
      end
      EXECUTE: begin
        alusrca_c = 1'b1;
        aluop_c   = ALUOP_FUNCT;
        state_d   = ALUWB;
      end
      ALUWB: begin
        regdst_c   = 1'b1;
        regwrite_c = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alusrca_c = 1'b1;
        aluop_c   = ALUOP_SUB;
        pcsrc_c   = PCSRC_ALUOUT;
`ifdef MULTICYCLE_CTRL_BNE_EN
        pcen_c    = (bus.op == OP_BNE) ? ~bus.zero : bus.zero;
`else
        pcen_c    = bus.zero;
`endif
        state_d   = FETCH;
      end
      ADDIEX: begin
        alusrca_c = 1'b1;
        alusrcb_c = SRCB_IMM;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        regwrite_c = 1'b1;
        state_d    = FETCH;
      end
      JUMP: begin
        pcsrc_c = PCSRC_JUMP;
        pcen_c  = 1'b1;
        state_d = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Write enables are gated by reset itself so nothing strobes while reset is held.
  assign bus.pcen     = pcen_c & ~reset;
  assign bus.irwrite  = irwrite_c & ~reset;
  assign bus.memwrite = memwrite_c & ~reset;
  assign bus.regwrite = regwrite_c & ~reset;
  assign bus.iord     = iord_c;
  assign bus.memtoreg = memtoreg_c;
  assign bus.regdst   = regdst_c;
  assign bus.alusrca  = alusrca_c;
  assign bus.alusrcb  = alusrcb_c;
  assign bus.aluop    = aluop_c;
  assign bus.pcsrc    = pcsrc_c;
  assign bus.illegal  = illegal_q;
  assign bus.timeout  = timeout_q;
  assign bus.halted   = (state_q == HALT);
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS-subset core. Sequences the shared ALU, memory port, IR and register file over several cycles per instruction. Emits the 2-bit aluop consumed by the existing ALU decoder, plus all mux selects and write enables. Adds a memory-ready wait handshake, a wait-timeout watchdog and an illegal-opcode halt.

Parameters:
TIMEOUT, 16, maximum consecutive cycles waiting on mem_ready in one memory state; 0 disables the watchdog.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
op  in  6  opcode from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
pcen  out  1  PC write enable
irwrite  out  1  IR write enable
memwrite  out  1  memory write strobe
regwrite  out  1  register-file write enable
iord  out  1  address select: 0 = PC, 1 = ALUOut
memtoreg  out  1  writeback select: 1 = memory data
regdst  out  1  destination select: 1 = rd, 0 = rt
alusrca  out  1  0 = PC, 1 = regA
alusrcb  out  2  00 = regB, 01 = const 4, 10 = signimm, 11 = signimm<<2
aluop  out  2  00 = add, 01 = sub, 10 = use funct
pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal  out  1  sticky: undecodable opcode seen
timeout  out  1  sticky: watchdog expired
halted  out  1  FSM in HALT

Behaviour:
- Reset is async: state <= FETCH, wait counter <= 0, illegal = timeout = 0. While reset is high, pcen, irwrite, memwrite and regwrite are forced 0. Selects take FETCH values.
- Outputs are combinational from state. pcen also depends on zero in BRANCH and on mem_ready in FETCH. Signals not listed for a state are 0.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. irwrite = pcen = mem_ready. On mem_ready go to DECODE; otherwise hold.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 -> EXECUTE
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other opcode -> HALT and set illegal.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next is MEMRD if op is lw, else MEMWR.
- MEMRD: iord=1. On mem_ready go to MEMWB.
- MEMWB: memtoreg=1, regdst=0, regwrite=1. Next FETCH.
- MEMWR: iord=1, memwrite=1 held for every cycle of the state. On mem_ready go to FETCH.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10. Next ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1. Next FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pcen=zero. Next FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next FETCH.
- JUMP: pcsrc=10, pcen=1. Next FETCH.
- HALT: all enables 0, halted=1. Only reset exits.
- Latency with mem_ready tied high: lw 5 cycles; sw, R-type and addi 4; beq and j 3.
- Watchdog (FETCH, MEMRD, MEMWR only):
  - Counter increments on each cycle with mem_ready=0 and saturates at TIMEOUT.
  - It clears on mem_ready=1 and on leaving the state.
  - When the counter would reach TIMEOUT (TIMEOUT>0), the next state is HALT and timeout is set.
  - mem_ready=1 in the expiry cycle wins: the access completes normally.
- Reset mid-operation (e.g. in MEMWR): memwrite drops asynchronously and the FSM restarts at FETCH.

Optional Feature:
MULTICYCLE_CTRL_BNE_EN:
- Defined: op 000101 (bne) also goes to BRANCH. In BRANCH, pcen = ~zero when the current op is bne.
- Undefined: 000101 is illegal and goes to HALT.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT)
  - opcode constants
  - aluop, alusrcb and pcsrc encodings.
- One sub-module, mc_wait_timer: watchdog counter with inputs clk, reset, active, ready and output expire.

Test Plan:
- lw, mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5; irwrite=pcen=1 only in cycle 1.
- sw with mem_ready low 3 cycles in MEMWR -> memwrite high for exactly 4 cycles, then FETCH; regwrite never 1.
- beq with zero=1 -> pcen=1, pcsrc=01 in BRANCH; repeat with zero=0 -> pcen stays 0.
- op=111111 -> after DECODE, halted=1 and illegal=1, all enables 0 for 20 cycles; reset clears both.
- TIMEOUT=4, mem_ready stuck 0 in FETCH -> HALT entered 4 cycles after reset release, timeout=1; mem_ready=1 on cycle 4 -> normal DECODE, timeout=0.
- Reset asserted mid-MEMWR -> memwrite=0 the same cycle; after release, state is FETCH.
